up_counter_mod: RTL and testbench

//  - Synchronous modulo-N up counter: counts 0 -> MOD-1 and then wraps to 0.
//  - Ports: count enable, synchronous clear, parallel load, terminal-count level,

---
 rtl/up_counter_mod.sv | 82 ++++++++
 tb/tb_up_counter_mod.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/up_counter_mod.sv
// Synchronous modulo-MOD up counter with clear, clamped parallel load, terminal
// count, cascade carry and saturating wrap counter. Optional macro: UP_COUNTER_SATURATE_EN.
module up_counter_mod #(
  parameter int WIDTH  = 4,
  parameter int MOD    = 16,
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  counter,
  output logic              tc,
  output logic              carry,
  output logic [WCNT_W-1:0] wrap_cnt
);

  // Terminal value held one bit wider so MOD = 2**WIDTH compares without aliasing.
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MOD - 1);

  logic [WIDTH-1:0]  cnt_p0;
  logic [WCNT_W-1:0] wrap_p0;
  logic [WIDTH-1:0]  cnt_nxt;
  logic [WCNT_W-1:0] wrap_nxt;
  logic              at_last;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if ({1'b0, v} > LAST) return LAST[WIDTH-1:0];
    else                  return v;
  endfunction

  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] w);
    if (&w) return w;
    else    return w + WCNT_W'(1);
  endfunction

  function automatic logic [WIDTH-1:0] inc(input logic [WIDTH-1:0] v);
    return WIDTH'({1'b0, v} + (WIDTH+1)'(1));
  endfunction

  assign at_last = ({1'b0, cnt_p0} == LAST);

  always_comb begin
    cnt_nxt  = cnt_p0;
    wrap_nxt = wrap_p0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = clamp_load(load_val);
    end else if (en) begin
      if (at_last) begin
`ifdef UP_COUNTER_SATURATE_EN
        cnt_nxt = cnt_p0;
`else
        cnt_nxt  = '0;
        wrap_nxt = sat_inc(wrap_p0);
`endif
      end else begin
        cnt_nxt = inc(cnt_p0);
      end
    end
  end

  // stage p0: architectural state register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0  <= '0;
      wrap_p0 <= '0;
    end else begin
      cnt_p0  <= cnt_nxt;
      wrap_p0 <= wrap_nxt;
    end
  end

  assign counter  = cnt_p0;
  assign wrap_cnt = wrap_p0;
  assign tc       = at_last;
  assign carry    = at_last & en & ~clr & ~load & ~rst;

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed bench for up_counter_mod: scoreboard of model predictions compared per edge.
// Expectations follow UP_COUNTER_SATURATE_EN when the bench is built with it.
module tb_up_counter_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr, load;
  logic [3:0] load_val;
  logic [3:0] counter;
  logic       tc, carry;
  logic [7:0] wrap_cnt;

  logic       rst_b, en_b, clr_b, load_b;
  logic [3:0] lv_b;
  logic [3:0] counter_b, counter_c;
  logic       tc_b, tc_c, carry_b, carry_c;
  logic [1:0] wrap_b;
  logic [7:0] wrap_c;

  up_counter_mod #(.WIDTH(4), .MOD(10), .WCNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .counter(counter), .tc(tc), .carry(carry), .wrap_cnt(wrap_cnt));

  up_counter_mod #(.WIDTH(4), .MOD(10), .WCNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .clr(clr_b), .load(load_b), .load_val(lv_b),
    .counter(counter_b), .tc(tc_b), .carry(carry_b), .wrap_cnt(wrap_b));

  up_counter_mod #(.WIDTH(4), .MOD(16), .WCNT_W(8)) dut_c (
    .clk(clk), .rst(rst_b), .en(en_b), .clr(clr_b), .load(load_b), .load_val(lv_b),
    .counter(counter_c), .tc(tc_c), .carry(carry_c), .wrap_cnt(wrap_c));

  typedef struct packed {
    logic [3:0] cnt;
    logic       tc;
    logic [7:0] wrap;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_cnt = 0;
  int   m_wrap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic l, input logic e,
                      input logic [3:0] lv, input string tag);
    exp_t x;
    int   nc, nw;
    logic ec;
    rst = r; clr = c; load = l; en = e; load_val = lv;
    #1;
    ec = (m_cnt == 9) && e && !c && !l && !r;
    chk({tag, ".carry"}, 32'(carry), 32'(ec));
    nc = m_cnt;
    nw = m_wrap;
    if (r) begin
      nc = 0; nw = 0;
    end else if (c) begin
      nc = 0;
    end else if (l) begin
      nc = (lv > 9) ? 9 : int'(lv);
    end else if (e) begin
      if (m_cnt == 9) begin
`ifndef UP_COUNTER_SATURATE_EN
        nc = 0;
        nw = (m_wrap == 255) ? 255 : m_wrap + 1;
`endif
      end else begin
        nc = m_cnt + 1;
      end
    end
    m_cnt  = nc;
    m_wrap = nw;
    x.cnt  = 4'(nc);
    x.tc   = (nc == 9);
    x.wrap = 8'(nw);
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk({tag, ".counter"}, 32'(counter), 32'(x.cnt));
    chk({tag, ".tc"}, 32'(tc), 32'(x.tc));
    chk({tag, ".wrap"}, 32'(wrap_cnt), 32'(x.wrap));
  endtask

  initial begin
    rst_b = 1'b1; en_b = 1'b0; clr_b = 1'b0; load_b = 1'b0; lv_b = 4'd0;

    step(1, 0, 0, 0, 0, "rst0");
    step(1, 0, 0, 1, 0, "rst1");
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0, "count");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, "to5");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, "hold");
    step(0, 0, 1, 1, 4'd7, "load7");
    step(0, 0, 1, 0, 4'd13, "load13");
    step(0, 1, 0, 1, 0, "clr_at9");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, "to6");
    step(1, 0, 0, 1, 0, "rst_mid");
    step(0, 0, 0, 1, 0, "resume");
    step(0, 1, 1, 1, 4'd4, "clr_load");
    step(0, 0, 1, 0, 4'd9, "load9");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, "wrap2");
    step(0, 0, 1, 0, 4'd15, "load15");
    step(0, 0, 0, 1, 0, "at9_en");
    step(0, 1, 0, 1, 0, "clr_sat");
    step(1, 0, 0, 0, 0, "rst2");
    for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 0, "run15");
    step(0, 1, 0, 0, 0, "clr_end");

    chk("b.reset_wrap", 32'(wrap_b), 32'd0);
    chk("c.reset_cnt", 32'(counter_c), 32'd0);
    rst_b = 1'b0; en_b = 1'b1;
    repeat (45) @(posedge clk);
    #1;
`ifdef UP_COUNTER_SATURATE_EN
    chk("b.counter45", 32'(counter_b), 32'd9);
    chk("b.tc45", 32'(tc_b), 32'd1);
    chk("b.wrap45", 32'(wrap_b), 32'd0);
    chk("c.counter45", 32'(counter_c), 32'd15);
    chk("c.tc45", 32'(tc_c), 32'd1);
    chk("c.carry45", 32'(carry_c), 32'd1);
    chk("c.wrap45", 32'(wrap_c), 32'd0);
`else
    chk("b.counter45", 32'(counter_b), 32'd5);
    chk("b.tc45", 32'(tc_b), 32'd0);
    chk("b.wrap45", 32'(wrap_b), 32'd3);
    chk("c.counter45", 32'(counter_c), 32'd13);
    chk("c.tc45", 32'(tc_c), 32'd0);
    chk("c.carry45", 32'(carry_c), 32'd0);
    chk("c.wrap45", 32'(wrap_c), 32'd2);
`endif
    chk("b.carry45", 32'(carry_b), 32'(tc_b === 1'b1));
    repeat (10) @(posedge clk);
    #1;
`ifdef UP_COUNTER_SATURATE_EN
    chk("b.wrap55", 32'(wrap_b), 32'd0);
    chk("c.counter55", 32'(counter_c), 32'd15);
`else
    chk("b.wrap55", 32'(wrap_b), 32'd3);
    chk("c.counter55", 32'(counter_c), 32'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
